decoder_nto2n_pipe: RTL and testbench

DECODER_NTO2N_PIPE -- requirements
Module: decoder_nto2n_pipe

---
 rtl/decoder_nto2n_pipe.sv | 129 ++++++++++++
 tb/tb_decoder_nto2n_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_pipe.sv
// Registered N-to-2^N decoder (one-hot or one-cold) behind a 2-entry skid buffer.
// Define DECODER_NTO2N_PARITY_EN to add the in_par/err/err_clr parity check.
module decoder_nto2n_pipe #(
  parameter int  IN_W       = 2,
  parameter bit  ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
`ifdef DECODER_NTO2N_PARITY_EN
  input  logic             in_par,
  output logic             err,
  input  logic             err_clr,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_dec
);

  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

  function automatic logic [OUT_W-1:0] decode(input logic en, input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] hot;
    hot = en ? ({{(OUT_W-1){1'b0}}, 1'b1} << code) : {OUT_W{1'b0}};
    return hot ^ INACTIVE;
  endfunction

  function automatic logic parity_ok(input logic en, input logic [IN_W-1:0] code, input logic par);
    return ((^{en, code}) ^ par) == 1'b0;
  endfunction

  logic             r_main_vld;
  logic [OUT_W-1:0] r_main_dec;
  logic             r_skid_vld;
  logic [OUT_W-1:0] r_skid_dec;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_par_ok;
  logic             w_enq;
  logic             w_main_free;
  logic [OUT_W-1:0] w_dec;
  logic             w_main_vld_nxt;
  logic [OUT_W-1:0] w_main_dec_nxt;
  logic             w_skid_vld_nxt;
  logic [OUT_W-1:0] w_skid_dec_nxt;

  assign w_accept    = in_valid && r_in_ready;
  assign w_main_free = !r_main_vld || out_ready;
  assign w_dec       = decode(in_en, in_code);
`ifdef DECODER_NTO2N_PARITY_EN
  assign w_par_ok    = parity_ok(in_en, in_code, in_par);
`else
  assign w_par_ok    = 1'b1;
`endif
  assign w_enq       = w_accept && w_par_ok;

  // Skid valid implies main valid, and the skid only fills while in_ready is high,
  // so an enqueue never collides with a skid-to-main move.
  always_comb begin
    w_main_vld_nxt = r_main_vld;
    w_main_dec_nxt = r_main_dec;
    w_skid_vld_nxt = r_skid_vld;
    w_skid_dec_nxt = r_skid_dec;
    if (w_main_free) begin
      if (r_skid_vld) begin
        w_main_vld_nxt = 1'b1;
        w_main_dec_nxt = r_skid_dec;
        w_skid_vld_nxt = 1'b0;
      end else if (w_enq) begin
        w_main_vld_nxt = 1'b1;
        w_main_dec_nxt = w_dec;
      end else begin
        w_main_vld_nxt = 1'b0;
      end
    end else begin
      if (w_enq) begin
        w_skid_vld_nxt = 1'b1;
        w_skid_dec_nxt = w_dec;
      end else begin
        w_skid_vld_nxt = r_skid_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld <= 1'b0;
      r_main_dec <= INACTIVE;
      r_skid_vld <= 1'b0;
      r_skid_dec <= INACTIVE;
      r_in_ready <= 1'b0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_main_dec <= w_main_dec_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_skid_dec <= w_skid_dec_nxt;
      r_in_ready <= !w_skid_vld_nxt;
    end
  end

`ifdef DECODER_NTO2N_PARITY_EN
  logic r_err;

  // A new parity error wins over err_clr on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_par_ok) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_vld;
  assign out_dec   = r_main_dec;

endmodule

// File: tb/tb_decoder_nto2n_pipe.sv
// Bench for decoder_nto2n_pipe: two instances (IN_W=2 one-hot, IN_W=3 one-cold)
// checked every cycle against a queue model of the buffered words.
module tb_decoder_nto2n_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_en = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] code = 3'd0;
  logic       rdy_a, rdy_b, ov_a, ov_b;
  logic [3:0] dec_a;
  logic [7:0] dec_b;
`ifdef DECODER_NTO2N_PARITY_EN
  logic bad = 1'b0;
  logic err_clr = 1'b0;
  logic par_a, par_b, err_a, err_b;
  assign par_a = (^{in_en, code[1:0]}) ^ bad;
  assign par_b = (^{in_en, code}) ^ bad;
`endif

  decoder_nto2n_pipe #(.IN_W(2), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_code(code[1:0]), .in_en(in_en),
`ifdef DECODER_NTO2N_PARITY_EN
    .in_par(par_a), .err(err_a), .err_clr(err_clr),
`endif
    .out_valid(ov_a), .out_ready(out_ready), .out_dec(dec_a));

  decoder_nto2n_pipe #(.IN_W(3), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_code(code), .in_en(in_en),
`ifdef DECODER_NTO2N_PARITY_EN
    .in_par(par_b), .err(err_b), .err_clr(err_clr),
`endif
    .out_valid(ov_b), .out_ready(out_ready), .out_dec(dec_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words from the decode rule: tag = {en, code[2:0]}
  function automatic logic [3:0] exp_a(input logic [3:0] t);
    return t[3] ? 4'(2 ** t[1:0]) : 4'd0;
  endfunction

  function automatic logic [7:0] exp_b(input logic [3:0] t);
    return ~(t[3] ? 8'(2 ** t[2:0]) : 8'd0);
  endfunction

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  bit mra = 1'b0, mrb = 1'b0, merr_a = 1'b0, merr_b = 1'b0;
  bit pa_ok, pb_ok;
  logic [3:0] cov_a = 4'd0;
  logic [7:0] cov_b = 8'd0;

  // Model: buffer occupancy is the queue length; ready while fewer than 2 words held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      mra = 1'b0;
      mrb = 1'b0;
      merr_a = 1'b0;
      merr_b = 1'b0;
    end else begin
      pa_ok = 1'b1;
      pb_ok = 1'b1;
`ifdef DECODER_NTO2N_PARITY_EN
      pa_ok = ((^{in_en, code[1:0]}) ^ par_a) == 1'b0;
      pb_ok = ((^{in_en, code}) ^ par_b) == 1'b0;
      if (in_valid && mra && !pa_ok) merr_a = 1'b1;
      else if (err_clr) merr_a = 1'b0;
      if (in_valid && mrb && !pb_ok) merr_b = 1'b1;
      else if (err_clr) merr_b = 1'b0;
`endif
      if (qa.size() > 0 && out_ready) void'(qa.pop_front());
      if (qb.size() > 0 && out_ready) void'(qb.pop_front());
      if (in_valid && mra && pa_ok) qa.push_back({in_en, 1'b0, code[1:0]});
      if (in_valid && mrb && pb_ok) qb.push_back({in_en, code});
      mra = qa.size() < 2;
      mrb = qb.size() < 2;
    end
  end

  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [3:0] prev_a = 4'd0;
  logic [7:0] prev_b = 8'd0;

  always @(negedge clk) begin
    chk("in_ready_a", 32'(rdy_a), 32'(mra));
    chk("in_ready_b", 32'(rdy_b), 32'(mrb));
    chk("out_valid_a", 32'(ov_a), 32'(qa.size() > 0));
    chk("out_valid_b", 32'(ov_b), 32'(qb.size() > 0));
    if (qa.size() > 0) begin
      chk("out_dec_a", 32'(dec_a), 32'(exp_a(qa[0])));
      chk("active_bits_a", $countones(dec_a), qa[0][3] ? 1 : 0);
      if (qa[0][3]) cov_a[qa[0][1:0]] = 1'b1;
    end else if (!rst_n) begin
      chk("reset_dec_a", 32'(dec_a), 32'd0);
    end
    if (qb.size() > 0) begin
      chk("out_dec_b", 32'(dec_b), 32'(exp_b(qb[0])));
      chk("active_bits_b", $countones(~dec_b), qb[0][3] ? 1 : 0);
      if (qb[0][3]) cov_b[qb[0][2:0]] = 1'b1;
    end else if (!rst_n) begin
      chk("reset_dec_b", 32'(dec_b), 32'hFF);
    end
    if (rst_n && hold_a) chk("stall_stable_a", 32'(dec_a), 32'(prev_a));
    if (rst_n && hold_b) chk("stall_stable_b", 32'(dec_b), 32'(prev_b));
    hold_a = rst_n && ov_a && !out_ready;
    hold_b = rst_n && ov_b && !out_ready;
    prev_a = dec_a;
    prev_b = dec_b;
`ifdef DECODER_NTO2N_PARITY_EN
    chk("err_a", 32'(err_a), 32'(merr_a));
    chk("err_b", 32'(err_b), 32'(merr_b));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_a", 32'(dec_a), 32'h0);
    chk("rst_dec_b", 32'(dec_b), 32'hFF);
    chk("rst_ready_a", 32'(rdy_a), 32'd0);
    chk("rst_valid_a", 32'(ov_a), 32'd0);
    rst_n = 1'b1;
    chk("ready_held_low", 32'(rdy_a), 32'd0);
    step();
    chk("ready_after_reset", 32'(rdy_a), 32'd1);

    // Back-to-back sweep, one word per cycle
    out_ready = 1'b1;
    in_en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      code = 3'(i);
      step();
      chk("sweep_dec_a", 32'(dec_a), 32'(sweep[i]));
      chk("sweep_valid_a", 32'(ov_a), 32'd1);
    end

    code = 3'd5;
    step();
    chk("onecold_code5", 32'(dec_b), 32'hDF);
    in_en = 1'b0;
    step();
    chk("onecold_disabled", 32'(dec_b), 32'hFF);
    chk("onehot_disabled", 32'(dec_a), 32'h0);
    in_valid = 1'b0;
    step();
    chk("drained_valid", 32'(ov_a), 32'd0);

    // Backpressure: third word refused while both entries are full
    out_ready = 1'b0;
    in_en = 1'b1;
    in_valid = 1'b1;
    code = 3'd1;
    step();
    chk("bp_ready_1", 32'(rdy_a), 32'd1);
    code = 3'd2;
    step();
    chk("bp_ready_2", 32'(rdy_a), 32'd0);
    chk("bp_dec_2", 32'(dec_a), 32'b0010);
    code = 3'd3;
    step();
    chk("bp_hold", 32'(dec_a), 32'b0010);
    chk("bp_ready_3", 32'(rdy_a), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_second_word", 32'(dec_a), 32'b0100);
    chk("bp_ready_back", 32'(rdy_a), 32'd1);
    step();
    chk("bp_empty", 32'(ov_a), 32'd0);

    // Reset with two words buffered
    out_ready = 1'b0;
    in_valid = 1'b1;
    code = 3'd0;
    step();
    code = 3'd3;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov_a), 32'd0);
    chk("midrst_dec_b", 32'(dec_b), 32'hFF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("midrst_ready", 32'(rdy_a), 32'd1);
    chk("midrst_nothing", 32'(ov_a), 32'd0);
    out_ready = 1'b1;
    step();
    chk("midrst_nothing_2", 32'(ov_a), 32'd0);

`ifdef DECODER_NTO2N_PARITY_EN
    code = 3'd2;
    in_en = 1'b1;
    bad = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bad = 1'b0;
    chk("par_err_set", 32'(err_a), 32'd1);
    chk("par_no_word", 32'(ov_a), 32'd0);
    err_clr = 1'b1;
    bad = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bad = 1'b0;
    chk("par_err_priority", 32'(err_a), 32'd1);
    step();
    chk("par_err_clr", 32'(err_a), 32'd0);
    err_clr = 1'b0;
`endif

    // Random traffic with one reset pulse in the middle
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_en = ($urandom_range(0, 7) != 0);
      code = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef DECODER_NTO2N_PARITY_EN
      bad = ($urandom_range(0, 15) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
`endif
      if (i == 700) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("cover_codes_a", 32'(cov_a), 32'hF);
    chk("cover_codes_b", 32'(cov_b), 32'hFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
